// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART_TX among NUM_REQ clients: latches the
// winner's byte, pulses tx_req, then tracks tx_busy to report done or timeout.
module uart_tx_arbiter #(
   parameter int unsigned NUM_REQ        = 4,
   parameter int unsigned VLD_DATA_WIDTH = 8,
   parameter int unsigned BUSY_TIMEOUT   = 1024
) (
   input  logic                              CLK,
   input  logic                              rst,
   input  logic [NUM_REQ-1:0]                req_valid,
   input  logic [NUM_REQ*VLD_DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]                grant,
   output logic [NUM_REQ-1:0]                done,
   output logic                              timeout_err,
   output logic [VLD_DATA_WIDTH-1:0]         tx_din,
   output logic                              tx_req,
   input  logic                              tx_busy,
   output logic                              arb_busy,
   output logic [$clog2(NUM_REQ)-1:0]        cur_id
);

   localparam int unsigned      ID_W    = $clog2(NUM_REQ);
   localparam int unsigned      CNT_W   = $clog2(BUSY_TIMEOUT) + 1;
   localparam logic [ID_W-1:0]  LAST_ID = ID_W'(NUM_REQ - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BUSY_TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

   state_t                    state, state_nxt;
   logic [CNT_W-1:0]          cnt, cnt_nxt;
   logic [ID_W-1:0]           cur_id_nxt;
   logic [VLD_DATA_WIDTH-1:0] tx_din_nxt;
   logic [NUM_REQ-1:0]        grant_nxt, done_nxt;
   logic                      tx_req_nxt, timeout_nxt;

   logic [VLD_DATA_WIDTH-1:0] slot [NUM_REQ];
   logic [ID_W-1:0]           winner;
   logic                      found;
   logic [31:0]               idx;

   always_comb begin
      for (int unsigned i = 0; i < NUM_REQ; i++)
         slot[i] = req_data[i*VLD_DATA_WIDTH +: VLD_DATA_WIDTH];
   end

   // Scan starts one past the current owner and wraps modulo NUM_REQ, so the
   // owner itself is considered last.
   always_comb begin
      winner = cur_id;
      found  = 1'b0;
      idx    = '0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         idx = (32'(cur_id) + k) % NUM_REQ;
         if (!found && req_valid[idx[ID_W-1:0]]) begin
            found  = 1'b1;
            winner = idx[ID_W-1:0];
         end
      end
   end

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      cur_id_nxt  = cur_id;
      tx_din_nxt  = tx_din;
      grant_nxt   = '0;
      done_nxt    = '0;
      tx_req_nxt  = 1'b0;
      timeout_nxt = 1'b0;
      case (state)
         IDLE: begin
            if (found && !tx_busy) begin
               cur_id_nxt        = winner;
               tx_din_nxt        = slot[winner];
               grant_nxt[winner] = 1'b1;
               tx_req_nxt        = 1'b1;
               state_nxt         = ISSUE;
            end
         end
         ISSUE: begin
            cnt_nxt   = '0;
            state_nxt = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            if (tx_busy) begin
               state_nxt = WAIT_DONE;
            end else if (cnt == CNT_MAX) begin
               timeout_nxt = 1'b1;
               state_nxt   = IDLE;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         WAIT_DONE: begin
            if (!tx_busy) begin
               done_nxt[cur_id] = 1'b1;
               state_nxt        = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         cur_id      <= LAST_ID;
         tx_din      <= '0;
         grant       <= '0;
         done        <= '0;
         tx_req      <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         cur_id      <= cur_id_nxt;
         tx_din      <= tx_din_nxt;
         grant       <= grant_nxt;
         done        <= done_nxt;
         tx_req      <= tx_req_nxt;
         timeout_err <= timeout_nxt;
      end
   end

   assign arb_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: vector table, hand-written corner
// sequences and a randomized run against a transaction-level reference model.
module tb_uart_tx_arbiter;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int TO = 16;
   localparam int M_NORMAL = 0, M_HI = 1, M_LO = 2;

   logic           CLK = 1'b0;
   logic           rst;
   logic [N-1:0]   req_valid;
   logic [N*W-1:0] req_data;
   logic [N-1:0]   grant, done;
   logic           timeout_err;
   logic [W-1:0]   tx_din;
   logic           tx_req;
   logic           tx_busy = 1'b0;
   logic           arb_busy;
   logic [1:0]     cur_id;

   int n_chk  = 0;
   int n_fail = 0;

   int mode      = M_NORMAL;
   int rise_dly  = 2;
   int frame_len = 100;
   int lead      = 0;
   int left      = 0;

   always #5 CLK = ~CLK;

   uart_tx_arbiter #(.NUM_REQ(N), .VLD_DATA_WIDTH(W), .BUSY_TIMEOUT(TO)) dut (
      .CLK(CLK), .rst(rst), .req_valid(req_valid), .req_data(req_data),
      .grant(grant), .done(done), .timeout_err(timeout_err), .tx_din(tx_din),
      .tx_req(tx_req), .tx_busy(tx_busy), .arb_busy(arb_busy), .cur_id(cur_id)
   );

   // UART_TX stand-in: busy rises rise_dly cycles after tx_req, lasts frame_len cycles.
   always @(posedge CLK) begin
      if (mode == M_HI) begin
         tx_busy <= 1'b1; lead <= 0; left <= 0;
      end else if (mode == M_LO) begin
         tx_busy <= 1'b0; lead <= 0; left <= 0;
      end else begin
         if (left > 0) begin
            left <= left - 1;
            if (left == 1) tx_busy <= 1'b0;
         end else begin
            tx_busy <= 1'b0;
         end
         if (tx_req === 1'b1) lead <= rise_dly - 1;
         else if (lead > 1) lead <= lead - 1;
         else if (lead == 1) begin
            lead <= 0; tx_busy <= 1'b1; left <= frame_len;
         end
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: got no end of test, expected finish before 2ms");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic wait_grant(input int max, output logic [N-1:0] g);
      g = '0;
      for (int i = 0; i < max; i++) begin
         tick();
         if (grant != '0) begin
            g = grant;
            return;
         end
      end
   endtask

   task automatic wait_done(input int max, output logic [N-1:0] d,
                            output logic timing_ok, output logic busy_ok);
      logic b1, b2;
      d = '0; timing_ok = 1'b0; busy_ok = 1'b1; b1 = tx_busy; b2 = tx_busy;
      for (int i = 0; i < max; i++) begin
         tick();
         if (done != '0) begin
            d = done;
            timing_ok = (b1 == 1'b0) && (b2 == 1'b1);
            return;
         end
         if (!arb_busy) busy_ok = 1'b0;
         b2 = b1;
         b1 = tx_busy;
      end
   endtask

   function automatic int rr_pick(input logic [N-1:0] v, input int last);
      for (int k = 1; k <= N; k++)
         if (v[(last + k) % N]) return (last + k) % N;
      return -1;
   endfunction

   typedef struct {
      logic [N-1:0]   valid;
      logic [N*W-1:0] data;
      logic [N-1:0]   exp_grant;
      logic [W-1:0]   exp_din;
      int             exp_id;
   } vec_t;

   vec_t tbl [11];

   initial begin
      logic [N-1:0] g, d;
      logic         t_ok, b_ok, bad, fell;
      logic [N-1:0] prev_valid, exp_g, exp_d;
      logic [W-1:0] dat [N];
      logic [W-1:0] last_din;
      logic         idle_prev, prev_busy, in_flight, seen, done_due;
      int           last, owner, w;

      tbl[0]  = '{4'b0001, 32'h000000AB, 4'b0001, 8'hAB, 0};
      tbl[1]  = '{4'b0001, 32'h4433225A, 4'b0001, 8'h5A, 0};
      tbl[2]  = '{4'b1001, 32'h7F000001, 4'b1000, 8'h7F, 3};
      tbl[3]  = '{4'b1001, 32'h7F000001, 4'b0001, 8'h01, 0};
      tbl[4]  = '{4'b0110, 32'h00C3B200, 4'b0010, 8'hB2, 1};
      tbl[5]  = '{4'b0110, 32'h00C3B200, 4'b0100, 8'hC3, 2};
      tbl[6]  = '{4'b0100, 32'h00E40000, 4'b0100, 8'hE4, 2};
      tbl[7]  = '{4'b0101, 32'h00770066, 4'b0001, 8'h66, 0};
      tbl[8]  = '{4'b0101, 32'h00770066, 4'b0100, 8'h77, 2};
      tbl[9]  = '{4'b1110, 32'h99887700, 4'b1000, 8'h99, 3};
      tbl[10] = '{4'b0011, 32'h000055AA, 4'b0001, 8'hAA, 0};

      rst = 1'b1; req_valid = '0; req_data = '0;
      repeat (3) tick();
      chk("rst_grant",   64'(grant), 64'h0);
      chk("rst_done",    64'(done), 64'h0);
      chk("rst_timeout", 64'(timeout_err), 64'h0);
      chk("rst_tx_req",  64'(tx_req), 64'h0);
      chk("rst_tx_din",  64'(tx_din), 64'h0);
      chk("rst_cur_id",  64'(cur_id), 64'd3);
      chk("rst_arb_busy", 64'(arb_busy), 64'h0);
      rst = 1'b0;
      tick();

      // Contention: all four request at once, served 0,1,2,3.
      req_valid = 4'b1111; req_data = 32'h44332211;
      for (int i = 0; i < N; i++) begin
         wait_grant(200, g);
         chk("cont_grant", 64'(g), 64'(1 << i));
         chk("cont_din", 64'(tx_din), 64'(8'h11 * (i + 1)));
         req_valid[i] = 1'b0;
         wait_done(300, d, t_ok, b_ok);
         chk("cont_done", 64'(d), 64'(1 << i));
      end

      // Vector table, each record started from IDLE the cycle done was seen.
      for (int r = 0; r < 11; r++) begin
         req_valid = tbl[r].valid; req_data = tbl[r].data;
         tick();
         chk("tbl_grant",  64'(grant), 64'(tbl[r].exp_grant));
         chk("tbl_tx_req", 64'(tx_req), 64'h1);
         chk("tbl_din",    64'(tx_din), 64'(tbl[r].exp_din));
         chk("tbl_cur_id", 64'(cur_id), 64'(tbl[r].exp_id));
         chk("tbl_arb_busy", 64'(arb_busy), 64'h1);
         req_valid = '0;
         wait_done(300, d, t_ok, b_ok);
         chk("tbl_done", 64'(d), 64'(tbl[r].exp_grant));
         chk("tbl_done_timing", 64'(t_ok), 64'h1);
         chk("tbl_busy_held", 64'(b_ok), 64'h1);
         chk("tbl_din_hold", 64'(tx_din), 64'(tbl[r].exp_din));
      end
      frame_len = 20;

      // Busy gate: no grant while tx_busy is high.
      mode = M_HI;
      tick();
      req_valid = 4'b0010; req_data = 32'h00005500;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("gate_nogrant", 64'(grant), 64'h0);
      end
      mode = M_NORMAL;
      tick();
      chk("gate_release_busy", 64'(tx_busy), 64'h0);
      chk("gate_release_nogrant", 64'(grant), 64'h0);
      tick();
      chk("gate_grant", 64'(grant), 64'b0010);
      chk("gate_din", 64'(tx_din), 64'h55);
      req_valid = '0;
      wait_done(100, d, t_ok, b_ok);
      chk("gate_done", 64'(d), 64'b0010);

      // Timeout: tx_busy never rises.
      mode = M_LO;
      req_valid = 4'b0001; req_data = 32'h0000003C;
      tick();
      chk("to_grant", 64'(grant), 64'b0001);
      chk("to_tx_req", 64'(tx_req), 64'h1);
      req_valid = '0;
      bad = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         tick();
         if (timeout_err || done != '0 || !arb_busy) bad = 1'b1;
      end
      chk("to_early", 64'(bad), 64'h0);
      tick();
      chk("to_pulse", 64'(timeout_err), 64'h1);
      chk("to_no_done", 64'(done), 64'h0);
      chk("to_idle", 64'(arb_busy), 64'h0);
      tick();
      chk("to_pulse_end", 64'(timeout_err), 64'h0);
      mode = M_NORMAL;
      repeat (2) tick();

      // Mid-frame reset during WAIT_DONE, with requester 3 pending.
      req_valid = 4'b0100; req_data = 32'h005C0000;
      tick();
      chk("mfr_grant", 64'(grant), 64'b0100);
      req_valid = '0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (tx_busy) break;
      end
      chk("mfr_busy_up", 64'(tx_busy), 64'h1);
      tick();
      req_valid = 4'b1000; req_data = 32'hE1000000;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mfr_grant0",  64'(grant), 64'h0);
      chk("mfr_done0",   64'(done), 64'h0);
      chk("mfr_tx_req0", 64'(tx_req), 64'h0);
      chk("mfr_tx_din0", 64'(tx_din), 64'h0);
      chk("mfr_cur_id",  64'(cur_id), 64'd3);
      chk("mfr_arb_busy", 64'(arb_busy), 64'h0);
      chk("mfr_uart_still_busy", 64'(tx_busy), 64'h1);
      bad = 1'b0; fell = 1'b0;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (grant != '0 || done != '0) bad = 1'b1;
         if (!tx_busy) begin
            fell = 1'b1;
            break;
         end
      end
      chk("mfr_busy_fell", 64'(fell), 64'h1);
      chk("mfr_quiet", 64'(bad), 64'h0);
      tick();
      chk("mfr_grant_after", 64'(grant), 64'b1000);
      chk("mfr_din_after", 64'(tx_din), 64'hE1);
      chk("mfr_no_done", 64'(done), 64'h0);
      req_valid = '0;
      wait_done(100, d, t_ok, b_ok);
      chk("mfr_done_after", 64'(d), 64'b1000);
      repeat (2) tick();

      // Randomized clients against a transaction-level model.
      last = 3; owner = 0; last_din = 8'hE1;
      in_flight = 1'b0; seen = 1'b0; done_due = 1'b0;
      idle_prev = 1'b1; prev_busy = tx_busy; prev_valid = '0;
      for (int i = 0; i < N; i++) dat[i] = '0;
      for (int t = 0; t < 3000; t++) begin
         rise_dly  = $urandom_range(2, 4);
         frame_len = $urandom_range(3, 12);
         tick();
         exp_g = '0;
         w = -1;
         if (idle_prev && prev_valid != '0 && !prev_busy) begin
            w = rr_pick(prev_valid, last);
            exp_g[w] = 1'b1;
         end
         exp_d = '0;
         if (done_due) exp_d[owner] = 1'b1;
         chk("rnd_grant", 64'(grant), 64'(exp_g));
         chk("rnd_tx_req", 64'(tx_req), 64'(exp_g != '0));
         chk("rnd_done", 64'(done), 64'(exp_d));
         chk("rnd_timeout", 64'(timeout_err), 64'h0);
         if (w >= 0) begin
            last = w; owner = w; last_din = dat[w];
            in_flight = 1'b1; seen = 1'b0;
            chk("rnd_cur_id", 64'(cur_id), 64'(w));
            req_valid[w] = 1'b0;
         end
         if (done_due) begin
            in_flight = 1'b0; done_due = 1'b0;
         end
         if (in_flight && tx_busy) seen = 1'b1;
         else if (in_flight && seen && !tx_busy) done_due = 1'b1;
         chk("rnd_tx_din", 64'(tx_din), 64'(last_din));
         chk("rnd_arb_busy", 64'(arb_busy), 64'(in_flight));
         idle_prev = !in_flight;
         prev_busy = tx_busy;
         for (int i = 0; i < N; i++) begin
            if (!req_valid[i] && i != w && $urandom_range(0, 5) == 0) begin
               dat[i] = W'($urandom);
               req_data[i*W +: W] = dat[i];
               req_valid[i] = 1'b1;
            end
         end
         prev_valid = req_valid;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
